multiplier: RTL

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add unsigned multiplier.
// One operand pair is accepted per operation; the result appears after a fixed
// WIDTH-cycle RUN phase, independent of operand values. A start seen in the
// DONE cycle chains the next operation with no idle gap.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 finished
);

  // Iteration counter width: enough to hold WIDTH-1 with one bit of headroom.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // latched multiplicand
  logic [WIDTH-1:0]   mplr_q,  mplr_d;    // multiplier, shifted out LSB first; fills with product low bits
  logic [WIDTH:0]     acc_q,   acc_d;     // upper product half plus carry bit
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] p_q,     p_d;
  logic               busy_q,  busy_d;
  logic               fin_q,   fin_d;
  logic [WIDTH:0]     sum_s;

  // Conditional add of the multiplicand into the upper half, carry retained.
  always_comb begin
    if (mplr_q[0]) begin
      sum_s = acc_q + {1'b0, mcand_q};
    end else begin
      sum_s = acc_q;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = A;
          mplr_d  = B;
          acc_d   = {(WIDTH+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Shift {carry, acc, multiplier} right by one after the add.
        acc_d  = {1'b0, sum_s[WIDTH:1]};
        mplr_d = {sum_s[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last iteration: capture the fully shifted word straight into P.
          p_d     = {sum_s, mplr_q[WIDTH-1:1]};
          fin_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          mcand_d = A;
          mplr_d  = B;
          acc_d   = {(WIDTH+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= {WIDTH{1'b0}};
      mplr_q  <= {WIDTH{1'b0}};
      acc_q   <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      p_q     <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign P        = p_q;
  assign busy     = busy_q;
  assign finished = fin_q;

endmodule
